ex_stage_muldiv: RTL
====================

// Module: ex_stage_muldiv
// PURPOSE
//  Execute stage between ID/EX and EX/MEM registers. Consumes ID/EX outputs, computes ALU result,
//  branch target and zero flag, selects destination register, and registers all into EX/MEM outputs.
//  Owns HI/LO and an iterative 32-cycle mult/div FSM; asserts busy to stall upstream while iterating.
// PARAMETERS
//  ENABLE_MULDIV  1  0: funct 0x18-0x1B act as bubbles (no HI/LO update, busy never asserted)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  hit            in   1   global advance enable (0 = cache miss: all state, incl. FSM, holds)
//  read_data_1    in   32  rs operand
//  read_data_2    in   32  rt operand / store data
//  immeadiate     in   32  sign-extended immediate; [10:6] = shamt
//  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  in 1 each  ID/EX controls
//  alu_op         in   3   000 add,001 sub(beq),010 R-type(funct),011 and,100 or,101 slt,110 lui,111 add
//  rt, rd         in   5   destination candidates
//  funct          in   6   R-type function
//  next_pc        in   32  PC+4 of instruction
//  busy           out  1   combinational: FSM in BUSY; upstream must hold ID/EX
//  alu_result_out out  32  registered ALU / mfhi / mflo result
//  write_data_out out  32  registered read_data_2
//  write_reg_out  out  5   registered reg_dst ? rd : rt
//  branch_target_out out 32 registered next_pc + (immeadiate << 2), mod 2^32
//  zero_out       out  1   registered (ALU result == 0)
//  mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, branch_out  out 1 each  registered controls
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outputs 0, HI=LO=0, FSM IDLE, counter 0. Reset beats hit and aborts any op.
//  - Operand B = alu_src ? immeadiate : read_data_2. All add/sub wrap mod 2^32, no overflow trap.
//  - R-type funct: 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt signed, 2B sltu,
//    00 sll B by shamt, 02 srl, 03 sra, 10 mfhi, 12 mflo, 18 mult, 19 multu, 1A div, 1B divu;
//    unknown funct -> result 0, reg_write_out forced 0. lui: result = {imm[15:0],16'h0}.
//  - Latency 1 cycle: EX/MEM outputs update at the edge where hit=1 and FSM IDLE.
//  - hit=0: every register (outputs, HI/LO, FSM, counter, partial products) holds.
//  - FSM IDLE->BUSY on accepting funct 18-1B under alu_op=010: latch operands, counter<=0,
//    EX/MEM receives bubble (all control outs 0). BUSY: counter++ per hit=1 edge; at edge with
//    counter==31 write HI/LO and return IDLE. busy high exactly 32 hit=1 cycles.
//  - While BUSY: EX/MEM gets bubble each hit=1 edge; held ID/EX inputs ignored until IDLE.
//  - mult/multu: {HI,LO} = 64-bit product (signed / unsigned).
//  - div/divu: LO = quotient truncated toward zero, HI = remainder, sign follows dividend.
//  - Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. Signed 0x8000_0000 / -1: LO=0x8000_0000, HI=0.
//  - mfhi/mflo read HI/LO as of start of cycle; op issued right after a mult sees new HI/LO.
//  - zero_out from ALU result for every op (bubble: 0 result, zero_out=1, branch_out=0).
// TESTING
//  - add: rd1=5, rd2=7, alu_op=010, funct=20, reg_dst=1, rd=3 -> next edge alu_result=12, write_reg=3.
//  - beq: rd1=rd2=9, alu_op=001, branch=1, next_pc=0x100, imm=4 -> zero=1, branch_target=0x110.
//  - mult: rd1=-3, rd2=7, funct=18 -> busy 32 cycles, then mflo=0xFFFF_FFEB, mfhi=0xFFFF_FFFF.
//  - div -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; divu x/0 with x=0x55 -> LO=0xFFFF_FFFF, HI=0x55.
//  - hit=0 for 5 cycles mid-divide -> busy stays high, total busy = 37 cycles, same result.
//  - rst=1 at iteration 10 of mult -> next cycle busy=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/ex_stage_muldiv.sv
// Execute stage: ALU, branch target, destination select and EX/MEM register,
// plus HI/LO with an iterative 32-step multiply/divide unit.
module ex_stage_muldiv #(
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic [31:0] immeadiate,
  input  logic        reg_dst,
  input  logic        alu_src,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [31:0] next_pc,
  output logic        busy,
  output logic [31:0] alu_result_out,
  output logic [31:0] write_data_out,
  output logic [4:0]  write_reg_out,
  output logic [31:0] branch_target_out,
  output logic        zero_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        branch_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state, state_nx;

  logic [XLEN-1:0]  op_b;
  logic [4:0]       shamt;
  logic [XLEN-1:0]  alu_res;
  logic             funct_ok;
  logic             md_op;
  logic             md_start;
  logic             last_step;

  logic [XLEN-1:0]  hi, lo;
  logic [XLEN-1:0]  hi_w, lo_w, b_w;
  logic [CNT_W-1:0] counter;
  logic             md_div, neg_q, neg_r;

  logic [XLEN-1:0]  step_hi, step_lo;
  logic [XLEN-1:0]  fin_hi, fin_lo;

  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_abs, b_abs;

  assign op_b      = alu_src ? immeadiate : read_data_2;
  assign shamt     = immeadiate[10:6];
  assign md_op     = (alu_op == 3'b010) && (funct[5:2] == 4'b0110);
  assign md_start  = ENABLE_MULDIV && (state == IDLE) && md_op;
  assign last_step = (counter == CNT_W'(XLEN - 1));

  // Operand sign handling for signed mult/div (funct[0]=0 means signed)
  always_comb begin
    a_neg = ~funct[0] & read_data_1[XLEN-1];
    b_neg = ~funct[0] & read_data_2[XLEN-1];
    a_abs = a_neg ? (~read_data_1 + XLEN'(1)) : read_data_1;
    b_abs = b_neg ? (~read_data_2 + XLEN'(1)) : read_data_2;
  end

  // Main ALU; funct_ok drops for undefined R-type codes
  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (alu_op)
      3'b000, 3'b111: alu_res = read_data_1 + op_b;
      3'b001:         alu_res = read_data_1 - op_b;
      3'b011:         alu_res = read_data_1 & op_b;
      3'b100:         alu_res = read_data_1 | op_b;
      3'b101:         alu_res = {{(XLEN-1){1'b0}}, ($signed(read_data_1) < $signed(op_b))};
      3'b110:         alu_res = {immeadiate[15:0], 16'h0000};
      default: begin
        case (funct)
          6'h20, 6'h21: alu_res = read_data_1 + op_b;
          6'h22, 6'h23: alu_res = read_data_1 - op_b;
          6'h24:        alu_res = read_data_1 & op_b;
          6'h25:        alu_res = read_data_1 | op_b;
          6'h26:        alu_res = read_data_1 ^ op_b;
          6'h27:        alu_res = ~(read_data_1 | op_b);
          6'h2A:        alu_res = {{(XLEN-1){1'b0}}, ($signed(read_data_1) < $signed(op_b))};
          6'h2B:        alu_res = {{(XLEN-1){1'b0}}, (read_data_1 < op_b)};
          6'h00:        alu_res = op_b << shamt;
          6'h02:        alu_res = op_b >> shamt;
          6'h03:        alu_res = $unsigned($signed(op_b) >>> shamt);
          6'h10:        alu_res = hi;
          6'h12:        alu_res = lo;
          6'h18, 6'h19, 6'h1A, 6'h1B: alu_res = '0;
          default:      funct_ok = 1'b0;
        endcase
      end
    endcase
  end

  // One shift-add multiply step or one restoring divide step
  always_comb begin
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    sum     = {1'b0, hi_w} + (lo_w[0] ? {1'b0, b_w} : '0);
    shifted = {hi_w, lo_w[XLEN-1]};
    diff    = shifted - {1'b0, b_w};
    step_hi = sum[XLEN:1];
    step_lo = {sum[0], lo_w[XLEN-1:1]};
    if (md_div) begin
      if (!diff[XLEN]) begin
        step_hi = diff[XLEN-1:0];
        step_lo = {lo_w[XLEN-2:0], 1'b1};
      end else begin
        step_hi = shifted[XLEN-1:0];
        step_lo = {lo_w[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up of the final step into HI/LO values
  always_comb begin
    logic [2*XLEN-1:0] prod;
    prod   = {step_hi, step_lo};
    if (neg_q) prod = ~prod + (2*XLEN)'(1);
    fin_hi = prod[2*XLEN-1:XLEN];
    fin_lo = prod[XLEN-1:0];
    if (md_div) begin
      fin_lo = neg_q ? (~step_lo + XLEN'(1)) : step_lo;
      fin_hi = neg_r ? (~step_hi + XLEN'(1)) : step_hi;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state: only advances on hit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hit && md_start) state_nx = BUSY;
      BUSY:    if (hit && last_step) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    if (state == BUSY) busy = 1'b1;
  end

  // Mult/div working registers and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      hi_w    <= '0;
      lo_w    <= '0;
      b_w     <= '0;
      counter <= '0;
      md_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else if (hit) begin
      if (md_start) begin
        hi_w    <= '0;
        lo_w    <= a_abs;
        b_w     <= b_abs;
        counter <= '0;
        md_div  <= funct[1];
        neg_q   <= (a_neg ^ b_neg) && (read_data_2 != '0);
        neg_r   <= a_neg;
      end else if (state == BUSY) begin
        hi_w    <= step_hi;
        lo_w    <= step_lo;
        counter <= counter + CNT_W'(1);
        if (last_step) begin
          hi <= fin_hi;
          lo <= fin_lo;
        end
      end
    end
  end

  // EX/MEM pipeline register; bubbles while the mult/div unit owns the stage
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_out    <= '0;
      write_data_out    <= '0;
      write_reg_out     <= '0;
      branch_target_out <= '0;
      zero_out          <= 1'b0;
      mem_to_reg_out    <= 1'b0;
      reg_write_out     <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      branch_out        <= 1'b0;
    end else if (hit) begin
      if (state == BUSY || md_op) begin
        alu_result_out    <= '0;
        write_data_out    <= '0;
        write_reg_out     <= '0;
        branch_target_out <= '0;
        zero_out          <= 1'b1;
        mem_to_reg_out    <= 1'b0;
        reg_write_out     <= 1'b0;
        mem_read_out      <= 1'b0;
        mem_write_out     <= 1'b0;
        branch_out        <= 1'b0;
      end else begin
        alu_result_out    <= alu_res;
        write_data_out    <= read_data_2;
        write_reg_out     <= reg_dst ? rd : rt;
        branch_target_out <= next_pc + (immeadiate << 2);
        zero_out          <= (alu_res == '0);
        mem_to_reg_out    <= mem_to_reg;
        reg_write_out     <= reg_write & funct_ok;
        mem_read_out      <= mem_read;
        mem_write_out     <= mem_write;
        branch_out        <= branch;
      end
    end
  end

endmodule
